// File: rtl/timer_pkg.sv
// Shared definitions for the game countdown timer: the FSM state encoding,
// the BCD constants and a helper that clamps each BCD digit to 9.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_MAX  = 8'h99;

    // Force each nibble into the legal BCD range so a bad preset cannot
    // leave the counters holding a non-decimal digit.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] val);
        logic [7:0] res;
        res = BCD_ZERO;
        for (int i = 0; i < 2; i++) begin
            res[4*i +: 4] = (val[4*i +: 4] > 4'd9) ? 4'd9 : val[4*i +: 4];
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_dec2.sv
// Combinational two-digit BCD decrement. 00 wraps to 99 with borrow_out set,
// which is how the centisecond counter asks the seconds counter to step.
module bcd_dec2
    import timer_pkg::*;
(
    input  logic [7:0] val,
    output logic [7:0] result,
    output logic       borrow_out
);

    // borrow[0] is the decrement request itself; each digit that is 0 passes it on.
    logic [2:0] borrow;

    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit              = val[4*gi +: 4];
            assign result[4*gi +: 4]  = !borrow[gi]      ? digit :
                                        (digit == 4'd0)  ? BCD_MAX[3:0] :
                                                           digit - 4'd1;
            assign borrow[gi+1]       = borrow[gi] & (digit == 4'd0);
        end
    endgenerate

    assign borrow_out = borrow[2];

endmodule

// File: rtl/game_timer.sv
// Countdown game timer in BCD seconds.centiseconds. tick_10ms is synchronised
// and edge-detected so a wide pulse counts once; controls resolve with the
// priority load > pause > start > tick.
module game_timer
    import timer_pkg::*;
#(
    parameter logic [7:0] SEC_INIT = 8'h60,
    parameter logic [7:0] WARN_SEC = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_10ms,
    input  logic       load,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] sec_bcd,
    output logic [7:0] cs_bcd,
    output logic       running,
    output logic       warn,
    output logic       expired,
    output logic       done
);

    logic       sync1_reg;
    logic       sync2_reg;
    logic       edge_reg;
    logic       tick_pulse;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] sec_reg;
    logic [7:0] sec_next;
    logic [7:0] cs_reg;
    logic [7:0] cs_next;
    logic       done_reg;
    logic       done_next;

    logic [7:0] cs_dec;
    logic [7:0] sec_dec;
    logic       cs_borrow;
    logic       sec_borrow;
    logic       time_zero;

    bcd_dec2 u_cs_dec (
        .val        (cs_reg),
        .result     (cs_dec),
        .borrow_out (cs_borrow)
    );

    bcd_dec2 u_sec_dec (
        .val        (sec_reg),
        .result     (sec_dec),
        .borrow_out (sec_borrow)
    );

    // Two-flop synchroniser plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            edge_reg  <= 1'b0;
        end else begin
            sync1_reg <= tick_10ms;
            sync2_reg <= sync1_reg;
            edge_reg  <= sync2_reg;
        end
    end

    assign tick_pulse = sync2_reg & ~edge_reg;
    assign time_zero  = (sec_reg == BCD_ZERO) && (cs_reg == BCD_ZERO);

    // State, time and done registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            sec_reg   <= SEC_INIT;
            cs_reg    <= BCD_ZERO;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sec_reg   <= sec_next;
            cs_reg    <= cs_next;
            done_reg  <= done_next;
        end
    end

    // Next state and next time value; the first matching control wins.
    always_comb begin
        state_next = state_reg;
        sec_next   = sec_reg;
        cs_next    = cs_reg;
        if (load) begin
            state_next = ST_IDLE;
            sec_next   = bcd_clamp(load_sec);
            cs_next    = BCD_ZERO;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!pause && start && !time_zero) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_next = ST_PAUSE;
                    end else if (tick_pulse) begin
                        if (cs_borrow && sec_borrow) begin
                            // Already at 00.00: nothing left to count.
                            state_next = ST_EXPIRED;
                        end else begin
                            cs_next = cs_dec;
                            if (cs_borrow) begin
                                sec_next = sec_dec;
                            end
                            if (!cs_borrow && (cs_dec == BCD_ZERO) && (sec_reg == BCD_ZERO)) begin
                                state_next = ST_EXPIRED;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
        done_next = (state_next == ST_EXPIRED) && (state_reg != ST_EXPIRED);
    end

    // Outputs decoded from registered state only.
    always_comb begin
        sec_bcd = sec_reg;
        cs_bcd  = cs_reg;
        running = (state_reg == ST_RUN);
        warn    = (state_reg == ST_RUN) && (sec_reg < WARN_SEC);
        expired = (state_reg == ST_EXPIRED);
        done    = done_reg;
    end

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with hand-computed expectations.
module tb_game_timer;

    logic       clk;
    logic       reset;
    logic       tick_10ms;
    logic       load;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic [7:0] sec_bcd;
    logic [7:0] cs_bcd;
    logic       running;
    logic       warn;
    logic       expired;
    logic       done;

    int vectors   = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int t_cs;

    game_timer #(
        .SEC_INIT (8'h60),
        .WARN_SEC (8'h10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_10ms (tick_10ms),
        .load      (load),
        .load_sec  (load_sec),
        .start     (start),
        .pause     (pause),
        .sec_bcd   (sec_bcd),
        .cs_bcd    (cs_bcd),
        .running   (running),
        .warn      (warn),
        .expired   (expired),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which done is seen high.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [7:0] s, input logic [7:0] c);
        chk({tag, ".sec"}, {24'd0, sec_bcd}, {24'd0, s});
        chk({tag, ".cs"},  {24'd0, cs_bcd},  {24'd0, c});
    endtask

    task automatic chk_flags(input string tag, input logic r, input logic w, input logic e, input logic d);
        chk({tag, ".running"}, {31'd0, running}, {31'd0, r});
        chk({tag, ".warn"},    {31'd0, warn},    {31'd0, w});
        chk({tag, ".expired"}, {31'd0, expired}, {31'd0, e});
        chk({tag, ".done"},    {31'd0, done},    {31'd0, d});
    endtask

    // One-cycle tick; returns at the negedge right after the counters update.
    task automatic tick1();
        @(negedge clk) tick_10ms = 1'b1;
        @(negedge clk) tick_10ms = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk) begin load = 1'b1; load_sec = v; end
        @(negedge clk) load = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_pause();
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_10ms = 1'b0; load = 1'b0; load_sec = 8'h00;
        start = 1'b0; pause = 1'b0;
        repeat (3) @(negedge clk);
        chk_time("reset", 8'h60, 8'h00);
        chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        $display("step reset: sec=%h cs=%h", sec_bcd, cs_bcd);
        reset = 1'b0;

        // 01.00 counted down to 00.00 over 100 ticks.
        do_load(8'h01);
        chk_time("load01", 8'h01, 8'h00);
        pulse_start();
        chk("start.running", {31'd0, running}, 32'd1);
        t_cs = 100;
        for (int i = 1; i <= 100; i++) begin
            tick1();
            t_cs--;
            chk_time("count100", to_bcd(t_cs / 100), to_bcd(t_cs % 100));
            if (i == 1)
                chk_time("count100.first", 8'h00, 8'h99);
            if (i == 100)
                chk_flags("count100.end", 1'b0, 1'b0, 1'b1, 1'b1);
        end
        @(negedge clk);
        chk_flags("expired.hold", 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk("done.count", done_cnt, 32'd1);
        $display("step countdown: sec=%h cs=%h expired=%b", sec_bcd, cs_bcd, expired);

        // EXPIRED ignores start, pause and ticks.
        pulse_start();
        pulse_pause();
        tick1();
        chk_time("expired.ignore", 8'h00, 8'h00);
        chk_flags("expired.ignore", 1'b0, 1'b0, 1'b1, 1'b0);
        $display("step expired-ignore: expired=%b", expired);

        // Clamp of an illegal preset, and start refused at 00.00.
        do_load(8'hAF);
        chk_time("clamp", 8'h99, 8'h00);
        chk_flags("clamp", 1'b0, 1'b0, 1'b0, 1'b0);
        do_load(8'h00);
        pulse_start();
        chk("start_zero.running", {31'd0, running}, 32'd0);
        tick1();
        chk_time("start_zero", 8'h00, 8'h00);
        $display("step clamp/start-zero: sec=%h running=%b", sec_bcd, running);

        // A 5-cycle-wide tick counts once.
        do_load(8'h01);
        pulse_start();
        @(negedge clk) tick_10ms = 1'b1;
        repeat (5) @(negedge clk);
        tick_10ms = 1'b0;
        repeat (4) @(negedge clk);
        chk_time("wide_tick", 8'h00, 8'h99);
        $display("step wide-tick: sec=%h cs=%h", sec_bcd, cs_bcd);

        // Pause freezes the count at 00.50.
        repeat (49) tick1();
        chk_time("run50", 8'h00, 8'h50);
        chk("run50.warn", {31'd0, warn}, 32'd1);
        pulse_pause();
        chk_flags("paused", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) tick1();
        chk_time("paused.ticks", 8'h00, 8'h50);
        pulse_pause();
        chk("resumed.running", {31'd0, running}, 32'd1);
        tick1();
        chk_time("resumed.tick", 8'h00, 8'h49);
        chk("resumed.warn", {31'd0, warn}, 32'd1);
        $display("step pause: sec=%h cs=%h", sec_bcd, cs_bcd);

        // Pause coinciding with a detected tick: pause wins, tick dropped.
        @(negedge clk) tick_10ms = 1'b1;
        @(negedge clk) tick_10ms = 1'b0;
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        repeat (3) @(negedge clk);
        chk_time("pause_tick", 8'h00, 8'h49);
        chk("pause_tick.running", {31'd0, running}, 32'd0);
        pulse_pause();

        // Load + pause + tick in the same cycle during RUN: load wins.
        chk("pre_load.running", {31'd0, running}, 32'd1);
        @(negedge clk) tick_10ms = 1'b1;
        @(negedge clk) tick_10ms = 1'b0;
        @(negedge clk) begin load = 1'b1; pause = 1'b1; load_sec = 8'h42; end
        @(negedge clk) begin load = 1'b0; pause = 1'b0; end
        chk_time("load_prio", 8'h42, 8'h00);
        chk_flags("load_prio", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk_time("load_prio.later", 8'h42, 8'h00);
        $display("step load-priority: sec=%h cs=%h running=%b", sec_bcd, cs_bcd, running);

        // From reset value 60.00 down through the warn threshold.
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk_time("reset2", 8'h60, 8'h00);
        pulse_start();
        tick1();
        chk_time("from60", 8'h59, 8'h99);
        chk("from60.warn", {31'd0, warn}, 32'd0);
        repeat (4999) tick1();
        chk_time("at10", 8'h10, 8'h00);
        chk("at10.warn", {31'd0, warn}, 32'd0);
        tick1();
        chk_time("at9_99", 8'h09, 8'h99);
        chk("at9_99.warn", {31'd0, warn}, 32'd1);
        repeat (3) tick1();
        chk_time("at9_96", 8'h09, 8'h96);
        $display("step warn: sec=%h cs=%h warn=%b", sec_bcd, cs_bcd, warn);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_time("async_reset", 8'h60, 8'h00);
        chk_flags("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("async_reset.done_cnt", done_cnt, 32'd1);
        $display("step async-reset: sec=%h cs=%h", sec_bcd, cs_bcd);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 The module SHALL have parameter SEC_INIT, default 8'h60, BCD seconds value loaded at reset.
REQ-002 The module SHALL have parameter WARN_SEC, default 8'h10, BCD threshold below which warn asserts.
REQ-003 The module SHALL have port clk, input, 1, the single system clock; all flops on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 The module SHALL have port tick_10ms, input, 1, 10 ms pulse from the clock divider; width one or more clk cycles.
REQ-006 The module SHALL have port load, input, 1, synchronous request to preset the time.
REQ-007 The module SHALL have port load_sec, input, 8, BCD seconds preset (two digits).
REQ-008 The module SHALL have port start, input, 1, begin counting from IDLE.
REQ-009 The module SHALL have port pause, input, 1, toggle between RUN and PAUSE.
REQ-010 The module SHALL have port sec_bcd, output, 8, current BCD seconds.
REQ-011 The module SHALL have port cs_bcd, output, 8, current BCD centiseconds.
REQ-012 The module SHALL have port running, output, 1, high while in RUN.
REQ-013 The module SHALL have port warn, output, 1, high in RUN when sec_bcd < WARN_SEC.
REQ-014 The module SHALL have port expired, output, 1, level, high in EXPIRED.
REQ-015 The module SHALL have port done, output, 1, single-cycle pulse on entry to EXPIRED.

Function
REQ-016 tick_10ms SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; one detected edge equals one tick, so a multi-cycle-wide pulse counts once.
REQ-017 A tick SHALL take effect on the counters 3 clk cycles after the tick_10ms rising edge.
REQ-018 States SHALL be IDLE, RUN, PAUSE and EXPIRED.
REQ-019 IDLE + start with time != 00.00 SHALL go to RUN; IDLE + start at 00.00 SHALL stay in IDLE.
REQ-020 In RUN, each tick SHALL decrement the time: cs != 00 gives cs-1; cs == 00 with sec != 00 gives cs=99 and sec-1.
REQ-021 In RUN, a tick that yields 00.00 SHALL move the state to EXPIRED in the same cycle; done SHALL be high for exactly that one cycle.
REQ-022 RUN + pause SHALL go to PAUSE; PAUSE + pause SHALL go to RUN; ticks in PAUSE SHALL be ignored.
REQ-023 load in any state SHALL set sec=load_sec, cs=00 and state=IDLE.
REQ-024 A load_sec digit > 9 SHALL be clamped to 9.
REQ-025 Same-cycle priority SHALL be load > pause > start > tick; a tick that coincides with a winning load or pause is dropped.
REQ-026 EXPIRED SHALL be left only by load or reset; start, pause and ticks SHALL be ignored there.
REQ-027 Outputs SHALL be registered or decoded from registered state only, with no input-to-output combinational path.

Reset
REQ-028 Reset SHALL give sec_bcd=SEC_INIT, cs_bcd=8'h00, state IDLE, synchronizer and edge flops 0, and running, warn, expired and done all 0.
REQ-029 Reset asserted mid-RUN SHALL abort the count immediately (asynchronously), with no done pulse.

Structure
REQ-030 A shared package timer_pkg SHALL hold the state encoding (2-bit enum), BCD_ZERO (8'h00) and BCD_MAX (8'h99).
REQ-031 A sub-module bcd_dec2 SHALL implement a combinational two-digit BCD decrement with a borrow-out; the module SHALL use two instances, one for cs and one for sec.

Verification
REQ-032 Reset, then load with load_sec=8'h01, start, then 100 ticks -> cs steps 00 to 99, 98, ... to 00 and sec 01 to 00; done pulses once on tick 100; expired=1.
REQ-033 Hold tick_10ms high for 5 clk cycles -> exactly one decrement.
REQ-034 In RUN at 00.50, pause, then 10 ticks -> still 00.50; pause again, then 1 tick -> 00.49.
REQ-035 load asserted in the same cycle as pause and a tick during RUN -> sec=load_sec, cs=00, state IDLE, running=0.
REQ-036 load with load_sec=8'hAF -> sec_bcd=8'h99; start at 00.00 -> stays IDLE.
REQ-037 With SEC_INIT=8'h60, start, then count down to 09.99 -> warn rises on the tick from 10.00 to 09.99; reset asserted mid-count -> 60.00, all flags 0, no done.
